// File: rtl/alu_flag_status.sv
// Flag status register with branch-condition query port, flag save/restore
// stack and a saturating overflow-event counter.
module alu_flag_status #(
    parameter int W     = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flags_valid,
    input  logic [W-1:0]     opcode,
    input  logic             negative,
    input  logic             overflow,
    input  logic             zero,
    input  logic             cout,
    output logic [3:0]       flags,
    input  logic             push,
    input  logic             pop,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             stack_err,
    input  logic             cond_valid,
    input  logic [3:0]       cond_code,
    output logic             cond_ready,
    output logic             res_valid,
    output logic             res_taken,
    input  logic             res_ready,
    input  logic             ovf_clr,
    output logic [CNT_W-1:0] ovf_count
);
    // alu_ops encodings of the two arithmetic ops that define C and V
    localparam logic [W-1:0] ADD_OP = W'(0);
    localparam logic [W-1:0] SUB_OP = W'(1);

    localparam int PTR_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] FULL_CNT = PTR_W'(DEPTH);

    // flags bit order: {N, Z, C, V}
    logic [3:0]       flags_q, flags_d;
    logic [3:0]       stack_q [DEPTH];
    logic [3:0]       stack_d [DEPTH];
    logic [PTR_W-1:0] cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             err_q, err_d;
    logic             res_valid_q, res_valid_d;
    logic             res_taken_q, res_taken_d;
    logic [CNT_W-1:0] ovf_q, ovf_d;

    logic             arith_op;
    logic             push_only, pop_only;
    logic             push_ok, pop_ok;
    logic             accept;
    logic             cond_hit;
    logic [IDX_W-1:0] wr_idx, rd_idx;

    function automatic logic eval_cond(input logic [3:0] code, input logic [3:0] f);
        logic n, z, c, v;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (code)
            4'd0:    eval_cond = z;
            4'd1:    eval_cond = !z;
            4'd2:    eval_cond = c;
            4'd3:    eval_cond = !c;
            4'd4:    eval_cond = n;
            4'd5:    eval_cond = !n;
            4'd6:    eval_cond = v;
            4'd7:    eval_cond = !v;
            4'd8:    eval_cond = c && !z;
            4'd9:    eval_cond = !c || z;
            4'd10:   eval_cond = (n == v);
            4'd11:   eval_cond = (n != v);
            4'd12:   eval_cond = !z && (n == v);
            4'd13:   eval_cond = z || (n != v);
            4'd14:   eval_cond = 1'b1;
            default: eval_cond = 1'b0;
        endcase
    endfunction

    assign arith_op   = (opcode == ADD_OP) || (opcode == SUB_OP);
    assign push_only  = push && !pop;
    assign pop_only   = pop && !push;
    assign push_ok    = push_only && !full_q;
    assign pop_ok     = pop_only && !empty_q;
    assign wr_idx     = IDX_W'(cnt_q);
    assign rd_idx     = IDX_W'(cnt_q - PTR_W'(1));
    assign cond_ready = !res_valid_q || res_ready;
    assign accept     = cond_valid && cond_ready;
    assign cond_hit   = eval_cond(cond_code, flags_q);

    always_comb begin
        flags_d = flags_q;
        stack_d = stack_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        // A legal pop overrides any same-cycle ALU flag update
        if (pop_ok) begin
            flags_d = stack_q[rd_idx];
            cnt_d   = cnt_q - PTR_W'(1);
        end else if (flags_valid) begin
            flags_d[3] = negative;
            flags_d[2] = zero;
            if (arith_op) begin
                flags_d[1] = cout;
                flags_d[0] = overflow;
            end
        end
        if (push_ok) begin
            stack_d[wr_idx] = flags_q;
            cnt_d           = cnt_q + PTR_W'(1);
        end
        if ((push && pop) || (push_only && full_q) || (pop_only && empty_q)) begin
            err_d = 1'b1;
        end
        full_d  = (cnt_d == FULL_CNT);
        empty_d = (cnt_d == '0);
    end

    always_comb begin
        res_valid_d = res_valid_q;
        res_taken_d = res_taken_q;
        if (accept) begin
            res_valid_d = 1'b1;
            res_taken_d = cond_hit;
        end else if (res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) begin
            ovf_d = '0;
        end else if (flags_valid && overflow && arith_op && !pop_ok && (ovf_q != '1)) begin
            ovf_d = ovf_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q     <= '0;
            cnt_q       <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            err_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_taken_q <= 1'b0;
            ovf_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            flags_q     <= flags_d;
            cnt_q       <= cnt_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            err_q       <= err_d;
            res_valid_q <= res_valid_d;
            res_taken_q <= res_taken_d;
            ovf_q       <= ovf_d;
            stack_q     <= stack_d;
        end
    end

    assign flags       = flags_q;
    assign stack_full  = full_q;
    assign stack_empty = empty_q;
    assign stack_err   = err_q;
    assign res_valid   = res_valid_q;
    assign res_taken   = res_taken_q;
    assign ovf_count   = ovf_q;
endmodule

// File: tb/tb_alu_flag_status.sv
// Directed self-checking bench for alu_flag_status with hand-computed expectations.
module tb_alu_flag_status;
    localparam int W     = 4;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam logic [W-1:0] ADD_OP = 4'd0;
    localparam logic [W-1:0] SUB_OP = 4'd1;
    localparam logic [W-1:0] AND_OP = 4'd2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flags_valid = 1'b0;
    logic [W-1:0]     opcode = '0;
    logic             negative = 1'b0, overflow = 1'b0, zero = 1'b0, cout = 1'b0;
    logic [3:0]       flags;
    logic             push = 1'b0, pop = 1'b0;
    logic             stack_full, stack_empty, stack_err;
    logic             cond_valid = 1'b0;
    logic [3:0]       cond_code = '0;
    logic             cond_ready;
    logic             res_valid, res_taken;
    logic             res_ready = 1'b1;
    logic             ovf_clr = 1'b0;
    logic [CNT_W-1:0] ovf_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] push_vals [4];
    logic [3:0] saved_vals [4];

    alu_flag_status #(.W(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flags_valid(flags_valid), .opcode(opcode),
        .negative(negative), .overflow(overflow), .zero(zero), .cout(cout),
        .flags(flags), .push(push), .pop(pop),
        .stack_full(stack_full), .stack_empty(stack_empty), .stack_err(stack_err),
        .cond_valid(cond_valid), .cond_code(cond_code), .cond_ready(cond_ready),
        .res_valid(res_valid), .res_taken(res_taken), .res_ready(res_ready),
        .ovf_clr(ovf_clr), .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alu(input logic v, input logic [W-1:0] op, input logic [3:0] nzcv);
        flags_valid = v;
        opcode      = op;
        negative    = nzcv[3];
        zero        = nzcv[2];
        cout        = nzcv[1];
        overflow    = nzcv[0];
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_flags"}, flags, 4'b0000);
        check({pfx, "_empty"}, stack_empty, 1'b1);
        check({pfx, "_full"}, stack_full, 1'b0);
        check({pfx, "_err"}, stack_err, 1'b0);
        check({pfx, "_res_valid"}, res_valid, 1'b0);
        check({pfx, "_res_taken"}, res_taken, 1'b0);
        check({pfx, "_ovf"}, ovf_count, 8'd0);
        check({pfx, "_cond_ready"}, cond_ready, 1'b1);
    endtask

    initial begin
        logic [3:0] exp_res [4];
        push_vals[0] = 4'b1010;
        push_vals[1] = 4'b0110;
        push_vals[2] = 4'b1100;
        push_vals[3] = 4'b0010;
        exp_res[0] = 1'b0;
        exp_res[1] = 1'b1;
        exp_res[2] = 1'b0;
        exp_res[3] = 1'b1;

        step();
        step();
        rst = 1'b0;
        check_reset_outputs("reset");

        // ADD loads all four flags, AND-type only N/Z
        set_alu(1'b1, ADD_OP, 4'b0011);
        step();
        check("add_flags", flags, 4'b0011);
        check("add_ovf", ovf_count, 8'd1);
        set_alu(1'b1, AND_OP, 4'b1000);
        step();
        check("and_flags", flags, 4'b1011);
        check("and_ovf", ovf_count, 8'd1);
        set_alu(1'b1, SUB_OP, 4'b1000);
        step();
        check("sub_flags", flags, 4'b1000);
        set_alu(1'b0, ADD_OP, 4'b0000);

        // GE/LT/GT/LE back to back on N=1,Z=0,C=0,V=0
        res_ready  = 1'b1;
        cond_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cond_code = 4'(10 + i);
            step();
            check($sformatf("q%0d_valid", 10 + i), res_valid, 1'b1);
            check($sformatf("q%0d_taken", 10 + i), res_taken, exp_res[i]);
        end
        cond_valid = 1'b0;
        step();
        check("drain_valid", res_valid, 1'b0);

        // Query alongside a flag update sees the old flags, next query the new ones
        cond_valid = 1'b1;
        cond_code  = 4'd0;
        set_alu(1'b1, AND_OP, 4'b0100);
        step();
        check("eq_old_taken", res_taken, 1'b0);
        check("eq_upd_flags", flags, 4'b0100);
        set_alu(1'b0, ADD_OP, 4'b0000);
        step();
        check("eq_new_taken", res_taken, 1'b1);
        cond_valid = 1'b0;
        step();

        // Backpressure holds the result and blocks new queries
        res_ready  = 1'b0;
        cond_valid = 1'b1;
        cond_code  = 4'd14;
        step();
        check("bp_valid", res_valid, 1'b1);
        check("bp_taken", res_taken, 1'b1);
        check("bp_ready_low", cond_ready, 1'b0);
        cond_code = 4'd15;
        step();
        check("bp_hold_taken", res_taken, 1'b1);
        check("bp_hold_valid", res_valid, 1'b1);
        res_ready = 1'b1;
        #1;
        check("bp_ready_high", cond_ready, 1'b1);
        step();
        check("nv_valid", res_valid, 1'b1);
        check("nv_taken", res_taken, 1'b0);
        cond_valid = 1'b0;
        step();
        check("nv_drain", res_valid, 1'b0);

        // Fill the stack: each push saves the pre-update flags
        saved_vals[0] = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            push = 1'b1;
            set_alu(1'b1, ADD_OP, push_vals[i]);
            step();
            if (i < 3) saved_vals[i+1] = push_vals[i];
            check($sformatf("push%0d_flags", i), flags, push_vals[i]);
            check($sformatf("push%0d_full", i), stack_full, (i == 3) ? 1'b1 : 1'b0);
            check($sformatf("push%0d_empty", i), stack_empty, 1'b0);
        end
        set_alu(1'b0, ADD_OP, 4'b0000);
        step();
        check("push5_err", stack_err, 1'b1);
        check("push5_full", stack_full, 1'b1);
        check("push5_flags", flags, 4'b0010);
        push = 1'b0;
        pop  = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            step();
            check($sformatf("pop%0d_flags", i), flags, saved_vals[i]);
            check($sformatf("pop%0d_full", i), stack_full, 1'b0);
            check($sformatf("pop%0d_empty", i), stack_empty, (i == 0) ? 1'b1 : 1'b0);
        end
        step();
        check("pop5_flags", flags, 4'b0100);
        check("pop5_empty", stack_empty, 1'b1);
        check("pop5_err", stack_err, 1'b1);
        pop = 1'b0;

        // Pop beats a concurrent overflowing ADD
        push = 1'b1;
        step();
        push = 1'b0;
        pop  = 1'b1;
        set_alu(1'b1, ADD_OP, 4'b1111);
        step();
        check("popadd_flags", flags, 4'b0100);
        check("popadd_ovf", ovf_count, 8'd1);
        check("popadd_empty", stack_empty, 1'b1);
        pop = 1'b0;

        // Saturation, then clear priority
        set_alu(1'b1, ADD_OP, 4'b0001);
        for (int i = 0; i < 300; i++) step();
        check("ovf_sat", ovf_count, 8'd255);
        ovf_clr = 1'b1;
        step();
        check("ovf_clr", ovf_count, 8'd0);
        ovf_clr = 1'b0;
        set_alu(1'b1, SUB_OP, 4'b0001);
        step();
        check("ovf_sub_inc", ovf_count, 8'd1);
        set_alu(1'b0, ADD_OP, 4'b0000);

        // Reset with a pending result and a non-empty stack
        res_ready  = 1'b0;
        cond_valid = 1'b1;
        cond_code  = 4'd14;
        push       = 1'b1;
        step();
        check("pre_rst_valid", res_valid, 1'b1);
        check("pre_rst_empty", stack_empty, 1'b0);
        cond_valid = 1'b0;
        push       = 1'b0;
        rst        = 1'b1;
        step();
        check_reset_outputs("midrst");
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
